// File: rtl/hv_bundle_encoder.sv
// Bundles N_FEAT level hypervectors into one thresholded sample HV; position binding by rotation under HV_BIND_EN.
// Latency: one feature per cycle, out_valid rises one cycle after the final accept.
// Backpressure: in_ready is low while a finished sample waits for out_ready; clr flushes the partial sample.
module hv_bundle_encoder #(
  parameter int unsigned D      = 10,
  parameter int unsigned N_FEAT = 8,
  parameter int unsigned THRESH = 4,
  parameter int unsigned CW     = $clog2(N_FEAT + 1)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [D-1:0]  level_hv,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [D-1:0]  out_hv,
  output logic [CW-1:0] feat_idx
);

  typedef enum logic {ACC, EMIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] feat_q, feat_d;
  logic [CW-1:0] cnt_q   [D];
  logic [CW-1:0] cnt_d   [D];
  logic [CW-1:0] cnt_sum [D];
  logic [D-1:0]  bound;
  logic [D-1:0]  hv_next;
  logic          hv_load;

`ifdef HV_BIND_EN
  int unsigned rot_amt;

  // Shifting right by D when rot_amt is 0 yields zero, so the OR is a plain rotate.
  always_comb begin
    rot_amt = 32'(feat_q) % D;
    bound   = (level_hv << rot_amt) | (level_hv >> (D - rot_amt));
  end
`else
  assign bound = level_hv;
`endif

  // The final feature is folded in here so the threshold sees the full sample.
  always_comb begin
    hv_next = '0;
    for (int i = 0; i < int'(D); i++) begin
      cnt_sum[i] = cnt_q[i] + CW'(bound[i]);
      hv_next[i] = (cnt_sum[i] >= CW'(THRESH));
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == EMIT);
  assign feat_idx  = feat_q;

  always_comb begin
    state_d = state_q;
    feat_d  = feat_q;
    cnt_d   = cnt_q;
    hv_load = 1'b0;
    case (state_q)
      ACC: begin
        if (in_valid) begin
          cnt_d  = cnt_sum;
          feat_d = feat_q + CW'(1);
          if (feat_q == CW'(N_FEAT - 1)) begin
            hv_load = 1'b1;
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          cnt_d   = '{default: '0};
          feat_d  = '0;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
    // Flush wins over any accept or handshake in the same cycle.
    if (clr) begin
      cnt_d   = '{default: '0};
      feat_d  = '0;
      state_d = ACC;
      hv_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ACC;
      feat_q  <= '0;
      cnt_q   <= '{default: '0};
      out_hv  <= '0;
    end else begin
      state_q <= state_d;
      feat_q  <= feat_d;
      cnt_q   <= cnt_d;
      if (hv_load) out_hv <= hv_next;
    end
  end

endmodule

// File: tb/tb_hv_bundle_encoder.sv
// Randomized bench for hv_bundle_encoder against a per-bit vote model of bound features.
module tb_hv_bundle_encoder;

  logic       clk = 1'b0;
  logic       nrst;
  logic       clr, in_valid, out_ready;
  logic [9:0] level_hv;
  logic       in_ready, out_valid;
  logic [9:0] out_hv;
  logic [1:0] feat_idx;

  logic       clr12, iv12, ordy12;
  logic [9:0] lv12;
  logic       ir12, ov12;
  logic [9:0] ohv12;
  logic [3:0] fi12;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] m_q[$];
  logic       m_emit = 1'b0;
  logic [9:0] m_hv   = '0;

  always #5 clk = ~clk;

  hv_bundle_encoder #(.D(10), .N_FEAT(3), .THRESH(2)) dut (
    .clk(clk), .nrst(nrst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .level_hv(level_hv), .out_valid(out_valid), .out_ready(out_ready),
    .out_hv(out_hv), .feat_idx(feat_idx)
  );

  hv_bundle_encoder #(.D(10), .N_FEAT(12), .THRESH(2)) dut12 (
    .clk(clk), .nrst(nrst), .clr(clr12), .in_valid(iv12), .in_ready(ir12),
    .level_hv(lv12), .out_valid(ov12), .out_ready(ordy12),
    .out_hv(ohv12), .feat_idx(fi12)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output bit i takes a vote from every feature k whose (bound) bit lands on i.
  function automatic logic [9:0] ref_bundle(input logic [9:0] f [16], input int n, input int thresh);
    logic [9:0] r;
    int c;
    int src;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      c = 0;
      for (int k = 0; k < n; k++) begin
`ifdef HV_BIND_EN
        src = (i - (k % 10) + 10) % 10;
`else
        src = i;
`endif
        if (f[k][src]) c++;
      end
      r[i] = (c >= thresh);
    end
    return r;
  endfunction

  function automatic logic [9:0] model_sample();
    logic [9:0] arr [16];
    for (int k = 0; k < 16; k++) arr[k] = (k < m_q.size()) ? m_q[k] : 10'h000;
    return ref_bundle(arr, m_q.size(), 2);
  endfunction

  // One clock: check outputs against the model, apply inputs, advance the model.
  task automatic cyc(input logic iv, input logic [9:0] hv, input logic ordy, input logic c);
    in_valid  = iv;
    level_hv  = hv;
    out_ready = ordy;
    clr       = c;
    chk("in_ready", {31'd0, in_ready}, {31'd0, !m_emit});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_emit});
    chk("feat_idx", {30'd0, feat_idx}, m_q.size());
    if (m_emit) chk("out_hv", {22'd0, out_hv}, {22'd0, m_hv});
    @(posedge clk);
    if (c) begin
      m_q.delete();
      m_emit = 1'b0;
    end else if (m_emit) begin
      if (ordy) begin
        m_emit = 1'b0;
        m_q.delete();
      end
    end else if (iv) begin
      m_q.push_back(hv);
      if (m_q.size() == 3) begin
        m_hv   = model_sample();
        m_emit = 1'b1;
      end
    end
    #1;
  endtask

  task automatic async_rst(input string tag);
    in_valid = 1'b0;
    clr      = 1'b0;
    nrst     = 1'b0;
    #1;
    chk({tag, "_ov"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ir"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_idx"}, {30'd0, feat_idx}, 32'd0);
    chk({tag, "_hv"}, {22'd0, out_hv}, 32'd0);
    m_q.delete();
    m_emit = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] exp_first;
    logic [9:0] exp12;
    logic [9:0] arr12 [16];
    logic [9:0] r;
    int n_ov;
`ifdef HV_BIND_EN
    exp_first = 10'h200;
    exp12     = 10'h003;
`else
    exp_first = 10'h000;
    exp12     = 10'h001;
`endif
    nrst = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; level_hv = '0;
    clr12 = 1'b0; iv12 = 1'b0; ordy12 = 1'b1; lv12 = '0;
    #2;
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_ir", {31'd0, in_ready}, 32'd1);
    chk("rst_idx", {30'd0, feat_idx}, 32'd0);
    chk("rst_hv", {22'd0, out_hv}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // Worked example: latency and expected bundle.
    cyc(1'b1, 10'h201, 1'b1, 1'b0);
    cyc(1'b1, 10'h100, 1'b1, 1'b0);
    cyc(1'b1, 10'h080, 1'b1, 1'b0);
    chk("tp_lat", {31'd0, out_valid}, 32'd1);
    chk("tp_hv", {22'd0, out_hv}, {22'd0, exp_first});
    cyc(1'b0, 10'h000, 1'b1, 1'b0);

    // Back-to-back samples with in_valid held high: one result every 4 cycles.
    n_ov = 0;
    for (int j = 0; j < 12; j++) begin
      r = (j < 4) ? 10'h3FF : (j < 8) ? 10'h000 : 10'($urandom);
      cyc(1'b1, r, 1'b1, 1'b0);
      if (out_valid) n_ov++;
      if (j == 2) chk("all_ones", {22'd0, out_hv}, 32'h3FF);
      if (j == 6) chk("all_zero", {22'd0, out_hv}, 32'h000);
    end
    chk("period", n_ov, 32'd3);

    // Backpressure: finish a sample, stall 5 cycles while offering inputs.
    cyc(1'b1, 10'($urandom), 1'b1, 1'b0);
    cyc(1'b1, 10'($urandom), 1'b1, 1'b0);
    for (int j = 0; j < 5; j++) cyc(1'b1, 10'h3FF, 1'b0, 1'b0);
    cyc(1'b1, 10'h3FF, 1'b1, 1'b0);
    for (int j = 0; j < 3; j++) cyc(1'b1, 10'($urandom), 1'b1, 1'b0);
    cyc(1'b0, 10'h000, 1'b1, 1'b0);

    // clr with a simultaneous input discards it and the partial sample.
    cyc(1'b1, 10'h001, 1'b1, 1'b0);
    cyc(1'b1, 10'h001, 1'b1, 1'b0);
    cyc(1'b1, 10'h001, 1'b1, 1'b1);
    chk("clr_idx", {30'd0, feat_idx}, 32'd0);
    for (int j = 0; j < 3; j++) cyc(1'b1, 10'h3FF, 1'b1, 1'b0);
    chk("clr_fresh", {22'd0, out_hv}, 32'h3FF);
    cyc(1'b0, 10'h000, 1'b1, 1'b0);

    // Asynchronous reset mid-accumulation and while holding a result.
    cyc(1'b1, 10'h3FF, 1'b1, 1'b0);
    cyc(1'b1, 10'h3FF, 1'b1, 1'b0);
    async_rst("arst_acc");
    for (int j = 0; j < 3; j++) cyc(1'b1, 10'($urandom), 1'b1, 1'b0);
    cyc(1'b0, 10'h000, 1'b1, 1'b0);
    for (int j = 0; j < 3; j++) cyc(1'b1, 10'h3FF, 1'b0, 1'b0);
    cyc(1'b0, 10'h000, 1'b0, 1'b0);
    async_rst("arst_emit");

    // Randomized traffic with biased corner values.
    for (int j = 0; j < 300; j++) begin
      case ($urandom_range(0, 7))
        0:       r = 10'h000;
        1:       r = 10'h3FF;
        default: r = 10'($urandom);
      endcase
      cyc($urandom_range(0, 3) != 0, r, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    cyc(1'b0, 10'h000, 1'b1, 1'b0);
    cyc(1'b0, 10'h000, 1'b1, 1'b0);
    in_valid = 1'b0;
    clr      = 1'b0;

    // Twelve features on a width-10 vector: rotation wraps past D.
    chk("n12_ir", {31'd0, ir12}, 32'd1);
    iv12 = 1'b1;
    lv12 = 10'h001;
    repeat (12) @(posedge clk);
    #1;
    iv12 = 1'b0;
    for (int k = 0; k < 16; k++) arr12[k] = 10'h001;
    chk("n12_ov", {31'd0, ov12}, 32'd1);
    chk("n12_idx", {28'd0, fi12}, 32'd12);
    chk("n12_hv", {22'd0, ohv12}, {22'd0, exp12});
    chk("n12_model", {22'd0, ohv12}, {22'd0, ref_bundle(arr12, 12, 2)});
    @(posedge clk);
    #1;
    chk("n12_drop", {31'd0, ov12}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hv_bundle_encoder.md
# hv_bundle_encoder

Downstream consumer of the item-memory fetch stage. Takes one 10-bit level hypervector per feature, binds each to its feature position by cyclic rotation, and accumulates per-bit counts over a fixed number of features. It then thresholds the counts into a single bundled sample hypervector. Input and output both use valid/ready handshakes, so the item-memory lookup can be driven straight from the quantizer and the result handed to the class-similarity stage.

## Interface
- `D`, 10: hypervector width; must match the fetch stage's `level_hv` width.
- `N_FEAT`, 8: features bundled per sample, legal range ≥1.
- `THRESH`, 4: output bit set when count ≥ `THRESH`, legal range 1..`N_FEAT`.
- `CW`, `$clog2(N_FEAT+1)`: counter width, derived; do not override.

Ports:
- `clk`  in  1  rising-edge clock.
- `nrst`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous flush of the partial sample.
- `in_valid`  in  1  `level_hv` is valid.
- `in_ready`  out  1  block accepts input.
- `level_hv`  in  D  level hypervector from the item-memory fetch stage.
- `out_valid`  out  1  `out_hv` holds a completed sample.
- `out_ready`  in  1  downstream accepts `out_hv`.
- `out_hv`  out  D  bundled, thresholded sample hypervector.
- `feat_idx`  out  CW  features accepted so far in the current sample (debug/monitor).

## Operation
- FSM with two states: ACC (accumulating) and EMIT (holding the result).
- ACC:
  - `in_ready`=1.
  - Accept on `in_valid` & `in_ready`: bound = `level_hv` rotated left by (`feat_idx` mod `D`).
  - Each counter `cnt[i]` += bound[i].
  - `feat_idx` += 1.
- Final feature: on the accept where `feat_idx` == `N_FEAT`-1:
  - `out_hv[i]` is registered as (`cnt[i]` + bound[i]) ≥ `THRESH`, so the final feature is included.
  - State goes to EMIT.
- EMIT:
  - `in_ready`=0; `in_valid` is ignored.
  - `out_valid`=1; `out_hv` is stable until the handshake.
- On `out_valid` & `out_ready`:
  - All `cnt` cleared, `feat_idx` cleared, state goes to ACC.
  - `out_valid` drops the next cycle.
- Arithmetic:
  - Counters are `CW` bits unsigned and cannot overflow (max `N_FEAT`).
  - Comparison is unsigned.
  - The rotation amount wraps modulo `D` when `N_FEAT` > `D`.
- `clr`:
  - In either state, `clr`=1 at a clock edge clears `cnt` and `feat_idx`, forces ACC, and drops `out_valid`.
  - `clr` has priority over a simultaneous input accept or output handshake; that input is discarded.
- Input values are not range-checked. All-zero `level_hv` (fetch stage disabled or out-of-range level) is accumulated as zeros.

## Timing
- Reset (`nrst`=0, asynchronous):
  - State ACC; `cnt`, `feat_idx` = 0.
  - `out_valid`=0, `out_hv`=0.
  - `in_ready`=1 (combinational from state).
- Throughput: one feature per cycle in ACC.
- Latency: `out_valid` rises 1 cycle after the final accept.
- Sample period (`out_ready` tied high): `N_FEAT`+1 cycles, including one EMIT cycle with `in_ready`=0.
- `in_ready` and `out_valid` are decoded from registered state only; neither depends combinationally on `in_valid` or `out_ready`.
- Reset asserted mid-sample discards the partial accumulation immediately; the first accept after release is feature 0.
- `out_hv` keeps its last value after the handshake until the next sample completes; it is only meaningful while `out_valid`=1.

## Configuration
- Macro: `HV_BIND_EN`.
- Defined: the position-binding rotation is applied as above.
- Undefined:
  - No rotation; `level_hv` is accumulated unmodified (pure bundling).
  - The rotator is removed from the datapath.
  - All other behaviour and timing are identical.

## Test plan
- Parameters `D`=10, `N_FEAT`=3, `THRESH`=2, `out_ready`=1, `HV_BIND_EN` defined.
  - Feed 10'h201, 10'h100, 10'h080 → `out_valid` 1 cycle after the 3rd accept, `out_hv`=10'h200.
  - Same stimulus with `HV_BIND_EN` undefined → `out_hv`=10'h000.
- Feed 10'h3FF ×3 → `out_hv`=10'h3FF. Feed 10'h000 ×3 → `out_hv`=10'h000. Back-to-back samples run with a period of 4 cycles.
- Backpressure: hold `out_ready`=0 for 5 cycles after completion while driving `in_valid`=1 with 10'h3FF.
  - Required: `out_hv` stable, `in_ready`=0, nothing accumulated.
  - The next sample equals the next 3 inputs after the handshake.
- After 2 accepts:
  - Pulse `clr` together with `in_valid` → `feat_idx`=0 and the input is discarded.
  - Separately, assert `nrst`=0 mid-sample → all outputs at reset values with no clock edge needed; the next sample is computed from fresh inputs only.
- Parameters `N_FEAT`=12, `THRESH`=2, `D`=10, feed 10'h001 ×12 → rotations wrap:
  - Bits 0 and 1 are counted twice; all other bits once.
  - `out_hv`=10'h003.
